// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a single-port RW SRAM macro; read data returns in order
// through a credit-guarded response FIFO. Optional zero-fill after reset: SRAM_REQ_CTRL_INIT_EN.
module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;

    // Handshakes: a request transfers at a posedge where req_valid && req_ready; a response
    // transfers at a posedge where rsp_valid && rsp_ready. Neither ready looks at its valid.

    logic                  rstb0_q, rstb0_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];

    logic             run_en;
    logic             init_busy;
    logic             accept;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] inflight;

`ifdef SRAM_REQ_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

    assign run_en    = (state_q == ST_RUN);
    assign init_busy = (state_q == ST_INIT) && rstb0_q;
`else
    assign run_en    = 1'b1;
    assign init_busy = 1'b0;
`endif

    // Every read already issued holds a FIFO slot, so a push can never find the FIFO full.
    assign inflight  = SUM_W'(count_q) + SUM_W'(s1_q) + SUM_W'(s2_q);
    assign req_ready = rstb0_q && run_en && (inflight < SUM_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = fifo_q[rd_ptr_q];
    assign push      = s2_q;
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = s1_q || s2_q || rsp_valid || init_busy;

    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;

    always_comb begin
        rstb0_d  = 1'b1;
        csb_d    = 1'b1;
        web_d    = 1'b1;
        addr_d   = addr_q;
        din_d    = din_q;
        s1_d     = accept && !req_we;
        s2_d     = s1_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            csb_d  = 1'b0;
            web_d  = !req_we;
            addr_d = req_addr;
            din_d  = req_wdata;
        end
`ifdef SRAM_REQ_CTRL_INIT_EN
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            csb_d       = 1'b0;
            web_d       = 1'b0;
            addr_d      = init_addr_q;
            din_d       = '0;
            init_addr_d = init_addr_q + 1'b1;
            if (&init_addr_q) state_d = ST_RUN;
        end
`endif
        // The macro's dout0 is valid at the second edge after the one that launched the read.
        if (push) begin
            fifo_d[wr_ptr_q] = sram_dout0;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            rstb0_q  <= 1'b0;
            csb_q    <= 1'b1;
            web_q    <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
`ifdef SRAM_REQ_CTRL_INIT_EN
            state_q     <= ST_INIT;
            init_addr_q <= '0;
`endif
        end else begin
            rstb0_q  <= rstb0_d;
            csb_q    <= csb_d;
            web_q    <= web_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
`ifdef SRAM_REQ_CTRL_INIT_EN
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk0) begin
        if (rstb0 && push) begin
            assert (count_q != CNT_W'(RSP_DEPTH))
            else $error("sram_req_ctrl: response push into a full FIFO");
        end
    end
`endif

endmodule
